// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage plus IF/ID pipeline register of the RV32I core.
// Keeps the PC, issues one word request at a time to instruction memory over
// a req/ack handshake, and registers each fetched word together with its PC.
// A one-entry buffer absorbs a response that arrives while decode is stalled.
// A redirect flushes IF/ID and refetches from the (word-aligned) target; a
// request that is still outstanding at that point is completed and dropped.
//
// Ports:
//   Clk_i          clock, rising edge
//   Reset_i        asynchronous reset, active high
//   IMemReq_o      fetch request (high in FETCH and DISCARD)
//   IMemAddr_o     fetch address, word aligned, stable until IMemAck_i
//   IMemAck_i      memory response valid, completes the request
//   IMemData_i     instruction word, valid with IMemAck_i
//   Stall_i        decode cannot accept, IF/ID holds
//   Redirect_i     taken branch/jump, flush and refetch
//   RedirectPc_i   redirect target PC
//   Instruction_o  IF/ID instruction (NOP_INSTR when invalid)
//   Pc_o           PC of Instruction_o
//   InstrValid_o   Instruction_o holds a real instruction
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned           WIDTH_DATA = 32,
  parameter logic [WIDTH_DATA-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [WIDTH_DATA-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  output logic                  IMemReq_o,
  output logic [WIDTH_DATA-1:0] IMemAddr_o,
  input  logic                  IMemAck_i,
  input  logic [WIDTH_DATA-1:0] IMemData_i,
  input  logic                  Stall_i,
  input  logic                  Redirect_i,
  input  logic [WIDTH_DATA-1:0] RedirectPc_i,
  output logic [WIDTH_DATA-1:0] Instruction_o,
  output logic [WIDTH_DATA-1:0] Pc_o,
  output logic                  InstrValid_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_OUT = 2'd2;
  localparam logic [1:0] ST_DISCARD  = 2'd3;

  localparam logic [WIDTH_DATA-1:0] PC_STEP = WIDTH_DATA'(3'd4);
  localparam logic [WIDTH_DATA-1:0] ZERO_W  = {WIDTH_DATA{1'b0}};

  logic [1:0]            state_q, state_d;
  logic [WIDTH_DATA-1:0] pc_q, pc_d;
  logic [WIDTH_DATA-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic [WIDTH_DATA-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH_DATA-1:0] buf_pc_q, buf_pc_d;
  logic [WIDTH_DATA-1:0] instr_q, instr_d;
  logic [WIDTH_DATA-1:0] pc_out_q, pc_out_d;
  logic                  valid_q, valid_d;

  logic                  load_s;
  logic [WIDTH_DATA-1:0] load_instr_s;
  logic [WIDTH_DATA-1:0] load_pc_s;
  logic                  ifid_free_s;
  logic [WIDTH_DATA-1:0] redirect_pc_s;
  logic                  unused_redirect_s;

  // Targets are forced onto a word boundary; the low bits are ignored.
  assign redirect_pc_s     = {RedirectPc_i[WIDTH_DATA-1:2], 2'b00};
  assign unused_redirect_s = ^RedirectPc_i[1:0];

  // IF/ID can take a new word if it is empty or decode is consuming it now.
  assign ifid_free_s = (!valid_q) || (!Stall_i);

  // Next-state logic for the fetch FSM, PC, buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    load_s       = 1'b0;
    load_instr_s = IMemData_i;
    load_pc_s    = pc_q;

    if (Redirect_i) begin
      pc_d = redirect_pc_s;
      case (state_q)
        ST_IDLE:     state_d = ST_FETCH;
        // Without an ack the old request is still in flight and must be
        // completed before the new address can be presented.
        ST_FETCH:    state_d = IMemAck_i ? ST_FETCH : ST_DISCARD;
        ST_WAIT_OUT: state_d = ST_FETCH;
        ST_DISCARD:  state_d = ST_DISCARD;
        default:     state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (IMemAck_i) begin
            if (ifid_free_s) begin
              load_s       = 1'b1;
              load_instr_s = IMemData_i;
              load_pc_s    = pc_q;
              pc_d         = pc_q + PC_STEP;
            end else begin
              buf_instr_d = IMemData_i;
              buf_pc_d    = pc_q;
              state_d     = ST_WAIT_OUT;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT_OUT: begin
          if (!Stall_i) begin
            load_s       = 1'b1;
            load_instr_s = buf_instr_q;
            load_pc_s    = buf_pc_q;
            pc_d         = pc_q + PC_STEP;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_WAIT_OUT;
          end
        end
        ST_DISCARD: begin
          if (IMemAck_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // The address register follows the PC whenever a fresh fetch starts and
    // otherwise holds, which keeps it stable across an outstanding request.
    if (state_d == ST_FETCH) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end
    req_d = (state_d == ST_FETCH) || (state_d == ST_DISCARD);

    // IF/ID: flush beats load beats hold; otherwise drain to a bubble.
    if (Redirect_i) begin
      instr_d  = NOP_INSTR;
      pc_out_d = pc_out_q;
      valid_d  = 1'b0;
    end else if (load_s) begin
      instr_d  = load_instr_s;
      pc_out_d = load_pc_s;
      valid_d  = 1'b1;
    end else if (Stall_i && valid_q) begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
    end else begin
      instr_d  = NOP_INSTR;
      pc_out_d = pc_out_q;
      valid_d  = 1'b0;
    end
  end

  // State, PC, memory interface, buffer and IF/ID registers.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= ZERO_W;
      instr_q     <= NOP_INSTR;
      pc_out_q    <= ZERO_W;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

  assign IMemReq_o     = req_q;
  assign IMemAddr_o    = addr_q;
  assign Instruction_o = instr_q;
  assign Pc_o          = pc_out_q;
  assign InstrValid_o  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed walk through reset, streaming, stall, redirect, wrap and
// asynchronous reset, followed by a randomized phase checked against a
// program-order model: decode must consume PCs in strict sequence (restarting
// at each redirect target), every valid word must equal memory at its PC,
// held and flushed cycles must look right, and requests must stay stable.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk_i = 1'b0;
  logic        Reset_i;
  logic        IMemReq_o;
  logic [31:0] IMemAddr_o;
  logic        IMemAck_i;
  logic [31:0] IMemData_i;
  logic        Stall_i;
  logic        Redirect_i;
  logic [31:0] RedirectPc_i;
  logic [31:0] Instruction_o;
  logic [31:0] Pc_o;
  logic        InstrValid_o;

  int errors = 0;
  int checks = 0;

  instruction_fetch dut (
    .Clk_i        (Clk_i),
    .Reset_i      (Reset_i),
    .IMemReq_o    (IMemReq_o),
    .IMemAddr_o   (IMemAddr_o),
    .IMemAck_i    (IMemAck_i),
    .IMemData_i   (IMemData_i),
    .Stall_i      (Stall_i),
    .Redirect_i   (Redirect_i),
    .RedirectPc_i (RedirectPc_i),
    .Instruction_o(Instruction_o),
    .Pc_o         (Pc_o),
    .InstrValid_o (InstrValid_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Memory contents: a few fixed words at the bottom, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hFFF0_0093;
      32'h0000_0004: mem_word = 32'h0000_0013;
      32'h0000_0008: mem_word = 32'h00A0_0113;
      32'h0000_000C: mem_word = 32'h0051_2023;
      default:       mem_word = a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; ack is only given against a live request.
  task automatic drive(input logic ack, input logic stall, input logic redir, input logic [31:0] rpc);
    IMemAck_i    = ack && IMemReq_o;
    IMemData_i   = IMemAck_i ? mem_word(IMemAddr_o) : 32'hDEAD_BEEF;
    Stall_i      = stall;
    Redirect_i   = redir;
    RedirectPc_i = rpc;
  endtask

  logic [31:0] exp_pc;
  int          consumed;
  logic [31:0] p_instr, p_pc, p_addr;
  logic        p_valid, p_stall, p_redir, p_req, p_ack;

  initial begin
    Reset_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    @(negedge Clk_i);
    check("rst_instr", Instruction_o, NOP);
    check("rst_pc",    Pc_o, 32'h0);
    check("rst_valid", {31'd0, InstrValid_o}, 32'd0);
    check("rst_req",   {31'd0, IMemReq_o}, 32'd0);
    check("rst_addr",  IMemAddr_o, 32'h0);
    Reset_i = 1'b0;

    // Back-to-back fetch with same-cycle ack
    @(negedge Clk_i);
    check("s_req0",  {31'd0, IMemReq_o}, 32'd1);
    check("s_addr0", IMemAddr_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("s_instr0", Instruction_o, 32'hFFF0_0093);
    check("s_pc0",    Pc_o, 32'h0);
    check("s_valid0", {31'd0, InstrValid_o}, 32'd1);
    check("s_addr4",  IMemAddr_o, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("s_instr4", Instruction_o, 32'h0000_0013);
    check("s_pc4",    Pc_o, 32'h4);
    check("s_valid4", {31'd0, InstrValid_o}, 32'd1);
    check("s_addr8",  IMemAddr_o, 32'h8);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("s_instr8", Instruction_o, 32'h00A0_0113);
    check("s_pc8",    Pc_o, 32'h8);
    check("s_valid8", {31'd0, InstrValid_o}, 32'd1);
    check("s_addrC",  IMemAddr_o, 32'hC);

    // Ack arrives during a 3-cycle stall: word parked, IF/ID holds
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk_i);
      check("st_hold_instr", Instruction_o, 32'h00A0_0113);
      check("st_hold_pc",    Pc_o, 32'h8);
      check("st_req_low",    {31'd0, IMemReq_o}, 32'd0);
      drive(1'b0, (i < 2), 1'b0, 32'h0);
    end
    @(negedge Clk_i);
    check("st_rel_instr", Instruction_o, 32'h0051_2023);
    check("st_rel_pc",    Pc_o, 32'hC);
    check("st_rel_valid", {31'd0, InstrValid_o}, 32'd1);
    check("st_rel_addr",  IMemAddr_o, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset while the request to 0x10 is outstanding
    #2 Reset_i = 1'b1;
    #1;
    check("ar_instr", Instruction_o, NOP);
    check("ar_pc",    Pc_o, 32'h0);
    check("ar_valid", {31'd0, InstrValid_o}, 32'd0);
    check("ar_req",   {31'd0, IMemReq_o}, 32'd0);
    check("ar_addr",  IMemAddr_o, 32'h0);
    @(negedge Clk_i);
    Reset_i = 1'b0;
    @(negedge Clk_i);
    check("ar_restart", IMemAddr_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("rd_pre_addr", IMemAddr_o, 32'h8);
    check("rd_pre_pc",   Pc_o, 32'h4);

    // Redirect to 0x100 while the 0x8 request waits; ack two cycles later
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    @(negedge Clk_i);
    check("rd_bubble_v", {31'd0, InstrValid_o}, 32'd0);
    check("rd_bubble_i", Instruction_o, NOP);
    check("rd_old_addr", IMemAddr_o, 32'h8);
    check("rd_old_req",  {31'd0, IMemReq_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("rd_old_addr2", IMemAddr_o, 32'h8);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("rd_drop_v",  {31'd0, InstrValid_o}, 32'd0);
    check("rd_pc_hold", Pc_o, 32'h4);
    check("rd_new_addr", IMemAddr_o, 32'h100);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("rd_tgt_pc",    Pc_o, 32'h100);
    check("rd_tgt_valid", {31'd0, InstrValid_o}, 32'd1);
    check("rd_tgt_instr", Instruction_o, mem_word(32'h100));

    // Redirect, ack and stall together: flush wins
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    @(negedge Clk_i);
    check("ra_valid", {31'd0, InstrValid_o}, 32'd0);
    check("ra_instr", Instruction_o, NOP);
    check("ra_addr",  IMemAddr_o, 32'h200);

    // Misaligned target near the top of memory; PC wraps to 0
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    @(negedge Clk_i);
    check("wr_addr", IMemAddr_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge Clk_i);
    check("wr_pc",    Pc_o, 32'hFFFF_FFFC);
    check("wr_valid", {31'd0, InstrValid_o}, 32'd1);
    check("wr_addr0", IMemAddr_o, 32'h0);

    // Randomized phase against the program-order model
    exp_pc   = 32'hFFFF_FFFC;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        r_stall, r_redir, r_ack;
      logic [31:0] r_tgt;
      if (c > 0) begin
        if (p_redir) begin
          check("rnd_flush_v", {31'd0, InstrValid_o}, 32'd0);
          check("rnd_flush_i", Instruction_o, NOP);
        end else if (p_valid && p_stall) begin
          check("rnd_hold_i", Instruction_o, p_instr);
          check("rnd_hold_p", Pc_o, p_pc);
          check("rnd_hold_v", {31'd0, InstrValid_o}, 32'd1);
        end
        if (p_req && !p_ack) begin
          check("rnd_req_stable",  {31'd0, IMemReq_o}, 32'd1);
          check("rnd_addr_stable", IMemAddr_o, p_addr);
        end
      end
      if (InstrValid_o) begin
        check("rnd_data", Instruction_o, mem_word(Pc_o));
      end
      check("rnd_align", {30'd0, IMemAddr_o[1:0]}, 32'd0);

      r_stall = ($urandom_range(99) < 30);
      r_redir = ($urandom_range(99) < 4);
      r_ack   = ($urandom_range(99) < 60);
      r_tgt   = $urandom;

      if (r_redir) begin
        exp_pc = {r_tgt[31:2], 2'b00};
      end else if (InstrValid_o && !r_stall) begin
        check("rnd_order", Pc_o, exp_pc);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end

      p_instr = Instruction_o;
      p_pc    = Pc_o;
      p_addr  = IMemAddr_o;
      p_valid = InstrValid_o;
      p_req   = IMemReq_o;
      p_stall = r_stall;
      p_redir = r_redir;
      drive(r_ack, r_stall, r_redir, r_tgt);
      p_ack   = IMemAck_i;
      @(negedge Clk_i);
    end
    check("rnd_progress", {31'd0, (consumed > 300)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage plus IF/ID pipeline register of the RV32I core.
- Maintains the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers each fetched instruction with its PC. Instruction_o feeds the immediate generator and decoder directly.
- Supports decode back-pressure (stall) and branch/jump redirect (flush).

Parameters:
- WIDTH_DATA, 32, instruction/data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on Instruction_o when invalid.

Ports:
- Clk_i  input  1  clock; all flops rising-edge.
- Reset_i  input  1  asynchronous reset, active-high.
- IMemReq_o  output  1  fetch request to instruction memory.
- IMemAddr_o  output  32  fetch address, word aligned.
- IMemAck_i  input  1  memory response valid; completes the request.
- IMemData_i  input  32  instruction word, valid when IMemAck_i=1.
- Stall_i  input  1  decode cannot accept; IF/ID register holds.
- Redirect_i  input  1  taken branch/jump; flush and refetch.
- RedirectPc_i  input  32  target PC for redirect.
- Instruction_o  output  32  IF/ID instruction.
- Pc_o  output  32  PC of Instruction_o.
- InstrValid_o  output  1  Instruction_o holds a real instruction.

Behaviour:
- Reset (asynchronous, Reset_i=1):
  - State=IDLE, PC=RESET_PC, buffer invalid.
  - Instruction_o=NOP_INSTR, Pc_o=0, InstrValid_o=0.
  - IMemReq_o=0, IMemAddr_o=RESET_PC.
- State machine (IMemReq_o=1 in FETCH and DISCARD only; IMemAddr_o is a register):
  - IDLE: entered only from reset. Goes to FETCH one cycle after reset release.
  - FETCH: request PC. IMemReq_o and IMemAddr_o stay stable until IMemAck_i. On ack:
    - IF/ID free (InstrValid_o=0 or Stall_i=0): load IF/ID with {IMemData_i, PC, valid=1}; PC<=PC+4; stay in FETCH, so the next request issues the following cycle.
    - IF/ID blocked (InstrValid_o=1 and Stall_i=1): capture {data, PC} in a one-entry buffer; go to WAIT_OUT.
  - WAIT_OUT: IMemReq_o=0. When Stall_i=0, move the buffer into IF/ID, PC<=PC+4, go to FETCH.
  - DISCARD: the old request is still outstanding after a redirect. Keep the old address asserted until ack; drop the returned data; then go to FETCH at the new PC.
- Latency: ack in cycle N gives Instruction_o/InstrValid_o updated at edge N+1. Sustained throughput is 1 instruction per cycle when memory acks in the same cycle as the request.
- IF/ID register update rules:
  - Stall_i=1 and InstrValid_o=1: hold all IF/ID outputs unchanged.
  - Stall_i=0 and no new instruction: insert a bubble (InstrValid_o<=0, Instruction_o<=NOP_INSTR); Pc_o holds.
- Redirect_i=1 (highest priority, over Stall_i and ack):
  - IF/ID flushed to a bubble. Buffer invalidated. PC<=RedirectPc_i with bits[1:0] forced to 0.
  - In FETCH with no ack that cycle: go to DISCARD.
  - In FETCH with ack the same cycle: data dropped; stay in FETCH; next request uses the new PC.
  - In WAIT_OUT: go to FETCH.
  - In DISCARD: PC updated again; stay in DISCARD.
  - In IDLE: PC updated; go to FETCH.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-request: outstanding request abandoned; the memory model must tolerate a withdrawn request.

Test Plan:
- Reset release, memory acks the same cycle as request, instructions 32'hFFF00093, 32'h00000013, 32'h00A00113 -> IMemAddr_o 0,4,8 on consecutive cycles; Instruction_o follows one cycle later with Pc_o 0,4,8; InstrValid_o=1 continuously.
- Stall_i=1 for 3 cycles while ack arrives with 32'h00512023 -> IF/ID holds its previous instruction; WAIT_OUT entered; IMemReq_o=0; after release, Instruction_o=32'h00512023 with Pc_o=previous+4; no instruction lost or duplicated.
- Redirect_i=1 to 32'h0000_0100 while request to 0x8 is outstanding (ack 2 cycles later) -> bubble immediately; data from 0x8 discarded; next IMemAddr_o=0x100; Pc_o=0x100 with valid.
- Redirect_i and IMemAck_i in the same cycle, with Stall_i=1 -> flush wins; InstrValid_o=0; next request to the redirect target.
- RedirectPc_i=32'hFFFF_FFFE -> PC=32'hFFFF_FFFC; following fetch address is 0 (wrap).
- Reset_i asserted mid-fetch -> outputs go to reset values immediately without waiting for a clock edge; fetch restarts at RESET_PC.
